hc595_chain_driver: RTL and testbench
=====================================

// Module: hc595_chain_driver
// PURPOSE
//  Serialises a parallel word into a daisy-chain of N_CHIPS 74HC595 shift registers.
//  It drives SER, SRCLK, RCLK and SRCLR_n, with a programmable SRCLK rate, bit order and latch width.
//  It is the multi-chip successor of the single-byte shift-register driver.
//  It sits between a control/sequencer block (valid/ready) and the FPGA pins.
// PARAMETERS
//  N_CHIPS     2   number of cascaded '595s; WIDTH = 8*N_CHIPS (localparam)
//  CLK_DIV     4   i_clk cycles per SRCLK half-period; legal range >= 1
//  LSB_FIRST   0   0: i_Data[WIDTH-1] shifted first; 1: i_Data[0] shifted first
//  LATCH_HOLD  2   i_clk cycles RCLK is held high; legal range >= 1
// PORTS
//  i_clk      in   1      system clock (48 MHz)
//  i_rst_n    in   1      asynchronous reset, active low
//  i_Data     in   WIDTH  word to display; captured on accept
//  i_Valid    in   1      request to send i_Data
//  i_Clear    in   1      request to clear the chain (SRCLR_n pulse, then latch)
//  o_Ready    out  1      high only in IDLE; accept = i_Valid & o_Ready
//  o_Done     out  1      1-cycle pulse when a frame or clear completes
//  o_SER      out  1      serial data to first chip
//  o_SRCLK    out  1      shift clock
//  o_RCLK     out  1      storage-register latch clock
//  o_SRCLR_n  out  1      shift-register clear, active low
// BEHAVIOUR
//  Reset (async, i_rst_n=0): state=IDLE.
//   Outputs: o_Ready=1, o_Done=0, o_SER=0, o_SRCLK=0, o_RCLK=0, o_SRCLR_n=1.
//   Bit and divider counters are set to 0.
//  All outputs are registered; no combinational path from any input to any output.
//  FSM states: IDLE, SH_LO, SH_HI, CLR, LATCH.
//  IDLE:
//   - i_Clear=1 -> CLR. i_Clear has priority over i_Valid if both are high.
//   - else i_Valid=1 -> capture i_Data into the internal shift reg, o_Ready=0, go to SH_LO.
//  SH_LO (CLK_DIV cycles):
//   - o_SRCLK=0; o_SER = current bit, stable for the whole state.
//   - Then go to SH_HI.
//  SH_HI (CLK_DIV cycles):
//   - o_SRCLK=1 (the '595 samples SER on this rising edge).
//   - At the end, advance the bit counter.
//   - If WIDTH bits have been sent -> LATCH, else -> SH_LO.
//  CLR (CLK_DIV cycles):
//   - o_SRCLR_n=0, o_SRCLK=0, o_SER=0.
//   - Then go to LATCH (exposes all-zero outputs).
//  LATCH (LATCH_HOLD cycles):
//   - o_RCLK=1, o_SRCLK=0.
//   - Then go to IDLE with o_Ready=1 and o_Done=1 for exactly that first IDLE cycle.
//  Timing:
//   - Data frame: o_Ready low for exactly 2*CLK_DIV*WIDTH + LATCH_HOLD cycles after the accept edge.
//   - Clear: o_Ready low for exactly CLK_DIV + LATCH_HOLD cycles.
//  Bit order:
//   - LSB_FIRST=0: the last bit shifted is i_Data[0]; i_Data[7:0] lands in the chip nearest the FPGA (Q7..Q0).
//   - LSB_FIRST=1 mirrors this ordering.
//  Exactly WIDTH rising SRCLK edges and one RCLK rising edge per data frame; zero SRCLK edges per clear.
//  i_Data is captured at accept; changes on i_Data, i_Valid or i_Clear outside IDLE are ignored.
//  Requests arriving while busy are not queued.
//  o_Done and o_Ready rising are simultaneous.
//  A new request may be accepted on that same cycle, giving back-to-back frames with one IDLE cycle between them.
//  Reset mid-frame:
//   - Outputs return to reset values immediately.
//   - No RCLK edge is produced, so the displayed pattern keeps the last latched value.
//   - The partially shifted chain content is discarded on the next frame.
//  Counters are sized with $clog2 and must never wrap inside a state; CLK_DIV=1 is legal.
// TESTING
//  All scenarios use N_CHIPS=2, CLK_DIV=2, LATCH_HOLD=2, LSB_FIRST=0.
//  1 Send 16'hA5C3 -> 16 SRCLK rises, SER sampled MSB-first = A5C3, one RCLK pulse 2 cycles wide.
//    o_Ready low 66 cycles, o_Done pulse once; model chain reads A5C3.
//  2 LSB_FIRST=1, send 16'h0001 -> first sampled SER bit is 1, the remaining 15 are 0.
//  3 i_Clear and i_Valid asserted together in IDLE -> SRCLR_n low 2 cycles, no SRCLK edges, RCLK pulse.
//    Model chain reads 0000; o_Ready low 4 cycles; i_Data is not sent.
//  4 Hold i_Valid high with 16'h1234 then 16'h5678 -> two back-to-back frames.
//    Exactly 1 IDLE cycle between them; i_Data changed mid-frame has no effect.
//  5 Assert i_rst_n=0 after 7 SRCLK rises of 16'hFFFF -> all outputs at reset values immediately.
//    No RCLK edge; previously latched value is retained; next frame 16'h00FF latches 00FF correctly.
//  6 CLK_DIV=1 -> SRCLK period is 2 cycles; frame length is 34 cycles.

Source files
------------

// File: rtl/hc595_chain_driver.sv
// hc595_chain_driver
// Shifts a WIDTH-bit word into a daisy chain of 74HC595 devices and latches it.
// The FSM walks SH_LO/SH_HI once per bit; CLR pulses SRCLR_n and LATCH strobes RCLK.
// Every pin is a flop fed from the next-state decode, so pins change together
// and no input reaches a pin combinationally.
module hc595_chain_driver #(
    parameter int N_CHIPS    = 2,
    parameter int CLK_DIV    = 4,
    parameter int LSB_FIRST  = 0,
    parameter int LATCH_HOLD = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [8*N_CHIPS-1:0]   i_Data,
    input  logic                   i_Valid,
    input  logic                   i_Clear,
    output logic                   o_Ready,
    output logic                   o_Done,
    output logic                   o_SER,
    output logic                   o_SRCLK,
    output logic                   o_RCLK,
    output logic                   o_SRCLR_n
);

    localparam int WIDTH   = 8 * N_CHIPS;
    localparam int CNT_MAX = (CLK_DIV > LATCH_HOLD) ? CLK_DIV : LATCH_HOLD;
    // +1 keeps the counters at least one bit wide when CLK_DIV = LATCH_HOLD = 1
    localparam int DIV_W   = $clog2(CNT_MAX + 1);
    localparam int BIT_W   = $clog2(WIDTH + 1);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] HOLD_LAST = DIV_W'(LATCH_HOLD - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SH_LO = 3'd1,
        S_SH_HI = 3'd2,
        S_CLR   = 3'd3,
        S_LATCH = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [DIV_W-1:0]   r_div;
    logic [DIV_W-1:0]   w_div_next;
    logic [BIT_W-1:0]   r_bit;
    logic [BIT_W-1:0]   w_bit_next;
    logic [WIDTH-1:0]   r_shreg;
    logic [WIDTH-1:0]   w_shreg_next;
    logic [WIDTH-1:0]   w_shreg_shifted;
    logic               w_ser_bit;

    logic               r_ready;
    logic               r_done;
    logic               r_ser;
    logic               r_srclk;
    logic               r_rclk;
    logic               r_srclr_n;
    logic               w_ready_next;
    logic               w_done_next;
    logic               w_ser_next;
    logic               w_srclk_next;
    logic               w_rclk_next;
    logic               w_srclr_n_next;

    // Shift register advanced by one bit in the configured direction
    always_comb begin
        w_shreg_shifted = r_shreg;
        if (LSB_FIRST != 0) begin
            w_shreg_shifted = {1'b0, r_shreg[WIDTH-1:1]};
        end else begin
            w_shreg_shifted = {r_shreg[WIDTH-2:0], 1'b0};
        end
    end

    // Bit presented on SER is the outgoing end of the next shift-register value
    always_comb begin
        w_ser_bit = 1'b0;
        if (LSB_FIRST != 0) begin
            w_ser_bit = w_shreg_next[0];
        end else begin
            w_ser_bit = w_shreg_next[WIDTH-1];
        end
    end

    // Next-state, divider, bit-counter and shift-register decode
    always_comb begin
        w_state_next = r_state;
        w_div_next   = r_div;
        w_bit_next   = r_bit;
        w_shreg_next = r_shreg;
        case (r_state)
            S_IDLE: begin
                w_div_next = {DIV_W{1'b0}};
                w_bit_next = {BIT_W{1'b0}};
                if (i_Clear) begin
                    w_state_next = S_CLR;
                    w_shreg_next = {WIDTH{1'b0}};
                end else if (i_Valid) begin
                    w_state_next = S_SH_LO;
                    w_shreg_next = i_Data;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_SH_LO: begin
                if (r_div == DIV_LAST) begin
                    w_div_next   = {DIV_W{1'b0}};
                    w_state_next = S_SH_HI;
                end else begin
                    w_div_next = r_div + {{(DIV_W-1){1'b0}}, 1'b1};
                end
            end
            S_SH_HI: begin
                if (r_div == DIV_LAST) begin
                    w_div_next   = {DIV_W{1'b0}};
                    w_shreg_next = w_shreg_shifted;
                    if (r_bit == BIT_LAST) begin
                        w_bit_next   = {BIT_W{1'b0}};
                        w_state_next = S_LATCH;
                    end else begin
                        w_bit_next   = r_bit + {{(BIT_W-1){1'b0}}, 1'b1};
                        w_state_next = S_SH_LO;
                    end
                end else begin
                    w_div_next = r_div + {{(DIV_W-1){1'b0}}, 1'b1};
                end
            end
            S_CLR: begin
                if (r_div == DIV_LAST) begin
                    w_div_next   = {DIV_W{1'b0}};
                    w_state_next = S_LATCH;
                end else begin
                    w_div_next = r_div + {{(DIV_W-1){1'b0}}, 1'b1};
                end
            end
            S_LATCH: begin
                if (r_div == HOLD_LAST) begin
                    w_div_next   = {DIV_W{1'b0}};
                    w_state_next = S_IDLE;
                end else begin
                    w_div_next = r_div + {{(DIV_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_div_next   = {DIV_W{1'b0}};
                w_bit_next   = {BIT_W{1'b0}};
            end
        endcase
    end

    // Pin values for the state being entered, so the registered pins track the state
    always_comb begin
        w_ready_next   = (w_state_next == S_IDLE);
        w_done_next    = (r_state == S_LATCH) && (w_state_next == S_IDLE);
        w_srclk_next   = (w_state_next == S_SH_HI);
        w_rclk_next    = (w_state_next == S_LATCH);
        w_srclr_n_next = (w_state_next != S_CLR);
        w_ser_next     = 1'b0;
        if ((w_state_next == S_SH_LO) || (w_state_next == S_SH_HI)) begin
            w_ser_next = w_ser_bit;
        end else begin
            w_ser_next = 1'b0;
        end
    end

    // State, counters and shift register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_div   <= {DIV_W{1'b0}};
            r_bit   <= {BIT_W{1'b0}};
            r_shreg <= {WIDTH{1'b0}};
        end else begin
            r_state <= w_state_next;
            r_div   <= w_div_next;
            r_bit   <= w_bit_next;
            r_shreg <= w_shreg_next;
        end
    end

    // Output pin registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ready   <= 1'b1;
            r_done    <= 1'b0;
            r_ser     <= 1'b0;
            r_srclk   <= 1'b0;
            r_rclk    <= 1'b0;
            r_srclr_n <= 1'b1;
        end else begin
            r_ready   <= w_ready_next;
            r_done    <= w_done_next;
            r_ser     <= w_ser_next;
            r_srclk   <= w_srclk_next;
            r_rclk    <= w_rclk_next;
            r_srclr_n <= w_srclr_n_next;
        end
    end

    assign o_Ready   = r_ready;
    assign o_Done    = r_done;
    assign o_SER     = r_ser;
    assign o_SRCLK   = r_srclk;
    assign o_RCLK    = r_rclk;
    assign o_SRCLR_n = r_srclr_n;

endmodule

// File: tb/tb_hc595_chain_driver.sv
// Bench for hc595_chain_driver: three instances (MSB-first CLK_DIV=2,
// LSB-first CLK_DIV=2, MSB-first CLK_DIV=1), each watched by a behavioural
// 74HC595 chain model. Directed vectors come from a table; clear, back-to-back
// and reset-mid-frame cases are written out by hand.
module tb_hc595_chain_driver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] data [3] = '{16'h0000, 16'h0000, 16'h0000};
    logic [2:0]  valid = 3'b000;
    logic [2:0]  clear = 3'b000;
    logic [2:0]  ready, done, ser, srclk, rclk, srclr_n;

    always #5 clk = ~clk;

    hc595_chain_driver #(.N_CHIPS(2), .CLK_DIV(2), .LSB_FIRST(0), .LATCH_HOLD(2)) u_msb (
        .i_clk(clk), .i_rst_n(rst_n), .i_Data(data[0]), .i_Valid(valid[0]), .i_Clear(clear[0]),
        .o_Ready(ready[0]), .o_Done(done[0]), .o_SER(ser[0]), .o_SRCLK(srclk[0]),
        .o_RCLK(rclk[0]), .o_SRCLR_n(srclr_n[0]));

    hc595_chain_driver #(.N_CHIPS(2), .CLK_DIV(2), .LSB_FIRST(1), .LATCH_HOLD(2)) u_lsb (
        .i_clk(clk), .i_rst_n(rst_n), .i_Data(data[1]), .i_Valid(valid[1]), .i_Clear(clear[1]),
        .o_Ready(ready[1]), .o_Done(done[1]), .o_SER(ser[1]), .o_SRCLK(srclk[1]),
        .o_RCLK(rclk[1]), .o_SRCLR_n(srclr_n[1]));

    hc595_chain_driver #(.N_CHIPS(2), .CLK_DIV(1), .LSB_FIRST(0), .LATCH_HOLD(2)) u_fast (
        .i_clk(clk), .i_rst_n(rst_n), .i_Data(data[2]), .i_Valid(valid[2]), .i_Clear(clear[2]),
        .o_Ready(ready[2]), .o_Done(done[2]), .o_SER(ser[2]), .o_SRCLK(srclk[2]),
        .o_RCLK(rclk[2]), .o_SRCLR_n(srclr_n[2]));

    // Chain model state and event counters, one slot per instance
    logic [15:0] chain   [3] = '{16'h0000, 16'h0000, 16'h0000};
    logic [15:0] latched [3] = '{16'h0000, 16'h0000, 16'h0000};
    int n_srclk [3] = '{0, 0, 0};
    int n_rclk  [3] = '{0, 0, 0};
    int n_rhi   [3] = '{0, 0, 0};
    int n_shi   [3] = '{0, 0, 0};
    int n_clr   [3] = '{0, 0, 0};
    int n_done  [3] = '{0, 0, 0};
    int n_busy  [3] = '{0, 0, 0};
    logic [2:0] p_srclk = 3'b000;
    logic [2:0] p_rclk  = 3'b000;

    // Behavioural '595 chain: shift on SRCLK rise, copy to outputs on RCLK rise, clear while SRCLR_n low
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (!srclr_n[k]) begin
                chain[k] <= 16'h0000;
                n_clr[k] <= n_clr[k] + 1;
            end else if (srclk[k] && !p_srclk[k]) begin
                chain[k]   <= {chain[k][14:0], ser[k]};
                n_srclk[k] <= n_srclk[k] + 1;
            end
            if (rclk[k] && !p_rclk[k]) begin
                latched[k] <= chain[k];
                n_rclk[k]  <= n_rclk[k] + 1;
            end
            if (rclk[k])   n_rhi[k]  <= n_rhi[k] + 1;
            if (srclk[k])  n_shi[k]  <= n_shi[k] + 1;
            if (done[k])   n_done[k] <= n_done[k] + 1;
            if (!ready[k]) n_busy[k] <= n_busy[k] + 1;
        end
        p_srclk <= srclk;
        p_rclk  <= rclk;
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    int s_srclk, s_rclk, s_rhi, s_shi, s_clr, s_done, s_busy;

    task automatic snap(input int k);
        s_srclk = n_srclk[k]; s_rclk = n_rclk[k]; s_rhi = n_rhi[k];
        s_shi = n_shi[k]; s_clr = n_clr[k]; s_done = n_done[k]; s_busy = n_busy[k];
    endtask

    // Wait (bounded) at falling edges until o_Ready of instance k is high
    task automatic wait_ready(input int k);
        int t;
        t = 0;
        while (!ready[k] && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) begin
            n_total++;
            $display("FAIL ready_timeout: dut %0d still busy after %0d cycles, expected idle", k, t);
        end
    endtask

    // One-cycle request, then wait for completion plus one cycle for the model to count o_Done
    task automatic req(input int k, input logic [15:0] d, input logic v, input logic c);
        snap(k);
        @(negedge clk);
        data[k] = d; valid[k] = v; clear[k] = c;
        @(negedge clk);
        valid[k] = 1'b0; clear[k] = 1'b0;
        wait_ready(k);
        @(negedge clk);
    endtask

    typedef struct {
        int          dut;
        logic [15:0] d;
        logic [15:0] exp;
        int          busy;
        int          hi;
    } vec_t;

    vec_t tbl [8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        // MSB-first: chain equals the word; LSB-first: chain is the bit-reversed word
        tbl[0] = '{0, 16'hA5C3, 16'hA5C3, 66, 32};
        tbl[1] = '{0, 16'h0000, 16'h0000, 66, 32};
        tbl[2] = '{0, 16'hFFFF, 16'hFFFF, 66, 32};
        tbl[3] = '{0, 16'h8001, 16'h8001, 66, 32};
        tbl[4] = '{1, 16'h0001, 16'h8000, 66, 32};
        tbl[5] = '{1, 16'hA5C3, 16'hC3A5, 66, 32};
        tbl[6] = '{2, 16'hA5C3, 16'hA5C3, 34, 16};
        tbl[7] = '{2, 16'h0F0F, 16'h0F0F, 34, 16};

        // Reset values while reset is held
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++)
            chk($sformatf("reset_outs_dut%0d", k),
                {ready[k], done[k], ser[k], srclk[k], rclk[k], srclr_n[k]}, 32'b100001);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed frames
        for (int i = 0; i < 8; i++) begin
            req(tbl[i].dut, tbl[i].d, 1'b1, 1'b0);
            chk($sformatf("v%0d_ready_low", i),  n_busy[tbl[i].dut] - s_busy, tbl[i].busy);
            chk($sformatf("v%0d_srclk_rises", i), n_srclk[tbl[i].dut] - s_srclk, 16);
            chk($sformatf("v%0d_srclk_hi", i),   n_shi[tbl[i].dut] - s_shi, tbl[i].hi);
            chk($sformatf("v%0d_rclk_rises", i), n_rclk[tbl[i].dut] - s_rclk, 1);
            chk($sformatf("v%0d_rclk_width", i), n_rhi[tbl[i].dut] - s_rhi, 2);
            chk($sformatf("v%0d_done", i),       n_done[tbl[i].dut] - s_done, 1);
            chk($sformatf("v%0d_latched", i),    latched[tbl[i].dut], tbl[i].exp);
        end

        // Clear wins over valid; data must not be sent
        req(0, 16'hBEEF, 1'b1, 1'b1);
        chk("clr_ready_low",   n_busy[0] - s_busy, 4);
        chk("clr_srclr_low",   n_clr[0] - s_clr, 2);
        chk("clr_srclk_rises", n_srclk[0] - s_srclk, 0);
        chk("clr_rclk_rises",  n_rclk[0] - s_rclk, 1);
        chk("clr_done",        n_done[0] - s_done, 1);
        chk("clr_latched",     latched[0], 16'h0000);

        // Back-to-back frames with i_Valid held; mid-frame data/clear changes ignored
        snap(0);
        @(negedge clk);
        data[0] = 16'h1234; valid[0] = 1'b1;
        @(negedge clk);
        data[0] = 16'h5678;
        chk("b2b_busy", ready[0], 1'b0);
        wait_ready(0);
        chk("b2b_done1",   done[0], 1'b1);
        chk("b2b_latch1",  latched[0], 16'h1234);
        @(negedge clk);
        chk("b2b_one_idle", ready[0], 1'b0);
        data[0] = 16'h0000; clear[0] = 1'b1;
        repeat (5) @(negedge clk);
        clear[0] = 1'b0; valid[0] = 1'b0;
        wait_ready(0);
        chk("b2b_latch2", latched[0], 16'h5678);
        @(negedge clk);
        chk("b2b_rclk_rises",  n_rclk[0] - s_rclk, 2);
        chk("b2b_srclk_rises", n_srclk[0] - s_srclk, 32);
        chk("b2b_done_count",  n_done[0] - s_done, 2);
        chk("b2b_no_clear",    n_clr[0] - s_clr, 0);

        // Reset after 7 SRCLK rises of FFFF
        snap(0);
        @(negedge clk);
        data[0] = 16'hFFFF; valid[0] = 1'b1;
        @(negedge clk);
        valid[0] = 1'b0;
        for (int t = 0; t < 500 && (n_srclk[0] - s_srclk) < 7; t++) @(negedge clk);
        chk("mid_rises_before_reset", n_srclk[0] - s_srclk, 7);
        rst_n = 1'b0;
        #1;
        chk("mid_reset_outs", {ready[0], done[0], ser[0], srclk[0], rclk[0], srclr_n[0]}, 32'b100001);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("mid_no_rclk",  n_rclk[0] - s_rclk, 0);
        chk("mid_retained", latched[0], 16'h5678);
        chk("mid_idle",     ready[0], 1'b1);
        req(0, 16'h00FF, 1'b1, 1'b0);
        chk("mid_next_latched", latched[0], 16'h00FF);
        chk("mid_next_busy",    n_busy[0] - s_busy, 66);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
